fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction-fetch stage that supersedes the single-register fetch unit. It keeps a fetch PC and issues requests to a synchronous instruction memory with one-cycle read latency. Returned words are held with their PCs in a small queue and handed to decode over a valid/ready handshake. Branch and jump redirects flush all stale fetches.

## Interface
Parameters:
- PC_WIDTH, 10, width of word-addressed PC
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 0, PC loaded on reset
- BUF_DEPTH, 2, queue entries (power of 2, >= 2)

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low reset
- branch_flag  in  1  redirect to branch_pc (highest priority)
- branch_pc  in  PC_WIDTH  branch target
- jump_flag  in  1  redirect to jump_pc
- jump_pc  in  PC_WIDTH  jump target
- stall  in  1  hazard stall; suppresses new memory requests
- imem_req  out  1  memory read request this cycle
- imem_addr  out  PC_WIDTH  read address (= fetch PC)
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_req
- instr  out  INSTR_WIDTH  queue head instruction
- instr_pc  out  PC_WIDTH  PC of instr
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decode accepts head when high with instr_valid

## Operation
- State:
  - fetch_pc register
  - inflight flag plus its PC
  - circular queue of {instr, pc} entries, with head/tail pointers and a count
- Redirect:
  - redirect = branch_flag | jump_flag; target = branch_flag ? branch_pc : jump_pc.
  - On redirect: fetch_pc <= target, the queue is flushed, the in-flight response is discarded, and no request is issued that cycle.
  - Redirect overrides stall.
- Issue:
  - imem_req = ~redirect & ~stall & (count + inflight - pop < BUF_DEPTH), where pop = instr_valid & instr_ready.
  - imem_addr = fetch_pc, combinational.
  - On issue: fetch_pc <= fetch_pc + 1 modulo 2^PC_WIDTH (2^PC_WIDTH-1 wraps to 0), inflight <= 1, and inflight PC <= fetch_pc. Otherwise inflight <= 0.
- Capture: if inflight and no redirect this cycle, {imem_rdata, inflight PC} is written at tail.
- Pop and capture in the same cycle: count is unchanged.
- Queue full: the credit rule guarantees capture never occurs when the queue is full. A capture into a full queue is a design error, and the bench asserts it never happens.
- Redirect with a simultaneous pop: the head counts as accepted by decode. All other entries are discarded.
- Stall: affects only issue. A pending in-flight word is still captured, and the queue still drains.
- instr / instr_pc: driven from the head entry, registered storage only, no bypass from imem_rdata.

## Timing
- Reset assertion (async, reset=0): fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, instr_valid=0, imem_req=0.
  - instr and instr_pc read as 0, because queue storage is cleared.
- Reset mid-operation: all queued and in-flight work is dropped immediately.
- First cycle after reset release: imem_req=1 with imem_addr=RESET_PC, unless stall or redirect.
- Sequential latency: request in cycle N, capture at end of N+1, instr_valid in N+2.
- Throughput: one instruction per cycle with BUF_DEPTH=2 and instr_ready held high.
- Redirect latency: flag sampled in cycle N, so the first target request is in N+1 and the target instruction is valid in N+3.
  - instr_valid=0 in N+1 and N+2, unless BUF_DEPTH entries are still mid-flight, which is not possible after a flush.
- Backpressure: with instr_ready=0, the queue fills to BUF_DEPTH and then imem_req stays 0. fetch_pc holds the next unissued address.

## Test plan
- Reset/stream: release reset with RESET_PC=0 and ready=1 → imem_addr 0,1,2,… on consecutive cycles; instr_pc 0,1,2,… starting 2 cycles after the first request, with no gaps.
- Backpressure: ready=0 from the cycle instr_pc=3 first appears → exactly BUF_DEPTH entries are held (pc 3,4) and imem_req drops to 0. Raising ready resumes pc 5,6,… with no loss or duplication.
- Branch vs jump: branch_flag (branch_pc=0x100) and jump_flag (jump_pc=0x200) asserted together in cycle N → next request 0x100 in N+1, and instr_pc=0x100 valid in N+3. No word from before N reaches decode after N.
- Stall: stall=1 for 3 cycles mid-stream → no requests during the stall, the in-flight word is still delivered, and the sequence continues contiguously afterwards. A redirect during the stall is taken.
- Wrap: jump to 0x3FE → delivered pcs 0x3FE, 0x3FF, 0x000, 0x001.
- Async reset mid-stream: drop reset between clock edges while the queue is full → instr_valid and imem_req go to 0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: issues reads to a one-cycle-latency instruction memory,
// queues returned words with their PCs, and hands them to decode over valid/ready.
module fetch_queue_unit #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 32,
    parameter int RESET_PC    = 0,
    parameter int BUF_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   branch_flag,
    input  logic [PC_WIDTH-1:0]    branch_pc,
    input  logic                   jump_flag,
    input  logic [PC_WIDTH-1:0]    jump_pc,
    input  logic                   stall,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(BUF_DEPTH);

    logic [PC_WIDTH-1:0]    fetch_pc_reg;
    logic                   inflight_reg;
    logic [PC_WIDTH-1:0]    inflight_pc_reg;
    logic [PTR_W-1:0]       head_reg;
    logic [PTR_W-1:0]       tail_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [INSTR_WIDTH-1:0] instr_mem [BUF_DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [BUF_DEPTH];

    logic                   redirect;
    logic [PC_WIDTH-1:0]    target;
    logic                   pop;
    logic                   capture;
    logic [CNT_W:0]         occupancy;
    logic                   credit;

    assign redirect    = branch_flag | jump_flag;
    assign target      = branch_flag ? branch_pc : jump_pc;
    assign instr_valid = (count_reg != '0);
    assign pop         = instr_valid & instr_ready;
    assign capture     = inflight_reg & ~redirect;

    // Credit counts the word already in flight so a returning word always has a slot.
    assign occupancy = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg) - (CNT_W + 1)'(pop);
    assign credit    = occupancy < DEPTH_V;

    // Gating by reset keeps the request low for as long as reset is held.
    assign imem_req  = reset & ~redirect & ~stall & credit;
    assign imem_addr = fetch_pc_reg;

    assign instr     = instr_mem[head_reg];
    assign instr_pc  = pc_mem[head_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg    <= PC_WIDTH'(RESET_PC);
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else begin
            if (redirect) begin
                fetch_pc_reg <= target;
            end else if (imem_req) begin
                fetch_pc_reg <= fetch_pc_reg + 1'b1;
            end

            inflight_reg <= imem_req;
            if (imem_req) begin
                inflight_pc_reg <= fetch_pc_reg;
            end

            // A flush drops everything; a head popped in the same cycle is still consumed.
            if (redirect) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (capture) begin
                    tail_reg <= tail_reg + 1'b1;
                end
                if (pop) begin
                    head_reg <= head_reg + 1'b1;
                end
                count_reg <= count_reg + CNT_W'(capture) - CNT_W'(pop);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                end else if (capture && (tail_reg == PTR_W'(gi))) begin
                    instr_mem[gi] <= imem_rdata;
                    pc_mem[gi]    <= inflight_pc_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: streaming, backpressure, redirects, stall, wrap, async reset.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_flag = 1'b0;
    logic [9:0]  branch_pc = '0;
    logic        jump_flag = 1'b0;
    logic [9:0]  jump_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;

    int compared = 0;
    int mismatched = 0;

    fetch_queue_unit #(
        .PC_WIDTH(10), .INSTR_WIDTH(32), .RESET_PC(0), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .branch_flag(branch_flag), .branch_pc(branch_pc),
        .jump_flag(jump_flag), .jump_pc(jump_pc),
        .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Memory word for address a is 0xC0DE0000 | a, returned one cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hC0DE_0000 | {22'd0, imem_addr};
    end

    // A capture into a full queue must never happen.
    always @(negedge clk) begin
        if (reset && dut.inflight_reg && !(branch_flag || jump_flag)) begin
            compared++;
            if (dut.count_reg == 2'd2) begin
                mismatched++;
                $display("FAIL capture_into_full got count=%0d want <2", dut.count_reg);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #3;
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want 0", imem_req); end
        compared++; if (imem_addr !== 10'd0) begin mismatched++; $display("FAIL reset_addr got %h want 000", imem_addr); end
        compared++; if (instr !== 32'd0) begin mismatched++; $display("FAIL reset_instr got %h want 0", instr); end
        compared++; if (instr_pc !== 10'd0) begin mismatched++; $display("FAIL reset_instr_pc got %h want 000", instr_pc); end
        $display("reset: valid=%b req=%b", instr_valid, imem_req);
    endtask

    // Release reset; addr 0..4 on consecutive cycles, instr_pc k-2 from cycle 2 on.
    task automatic test_stream();
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) reset = 1'b1;
            #1;
            compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL stream_req k=%0d got %b want 1", k, imem_req); end
            compared++; if (imem_addr !== 10'(k)) begin mismatched++; $display("FAIL stream_addr k=%0d got %h want %h", k, imem_addr, 10'(k)); end
            compared++; if (instr_valid !== (k >= 2)) begin mismatched++; $display("FAIL stream_valid k=%0d got %b want %b", k, instr_valid, (k >= 2)); end
            if (k >= 2) begin
                compared++; if (instr_pc !== 10'(k - 2)) begin mismatched++; $display("FAIL stream_pc k=%0d got %h want %h", k, instr_pc, 10'(k - 2)); end
                compared++; if (instr !== (32'hC0DE_0000 | 32'(k - 2))) begin mismatched++; $display("FAIL stream_instr k=%0d got %h want %h", k, instr, 32'hC0DE_0000 | 32'(k - 2)); end
            end
            $display("stream k=%0d: req=%b addr=%h valid=%b pc=%h", k, imem_req, imem_addr, instr_valid, instr_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_pc;
        step();
        instr_ready = 1'b0;
        #1;
        compared++; if (instr_pc !== 10'd3 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL bp_head0 got v=%b pc=%h want v=1 pc=003", instr_valid, instr_pc); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL bp_req0 got %b want 0", imem_req); end
        for (int j = 0; j < 3; j++) begin
            step();
            #1;
            compared++; if (instr_pc !== 10'd3 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold j=%0d got v=%b pc=%h want v=1 pc=003", j, instr_valid, instr_pc); end
            compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL bp_req j=%0d got %b want 0", j, imem_req); end
            compared++; if (imem_addr !== 10'd5) begin mismatched++; $display("FAIL bp_addr j=%0d got %h want 005", j, imem_addr); end
            $display("backpressure hold j=%0d: req=%b pc=%h", j, imem_req, instr_pc);
        end
        step();
        instr_ready = 1'b1;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 10'd5) begin mismatched++; $display("FAIL bp_resume_req got req=%b addr=%h want 1/005", imem_req, imem_addr); end
        compared++; if (instr_pc !== 10'd3) begin mismatched++; $display("FAIL bp_resume_pc got %h want 003", instr_pc); end
        for (int j = 0; j < 3; j++) begin
            step();
            #1;
            exp_pc = 10'(4 + j);
            compared++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin mismatched++; $display("FAIL bp_drain j=%0d got v=%b pc=%h want v=1 pc=%h", j, instr_valid, instr_pc, exp_pc); end
            compared++; if (instr !== (32'hC0DE_0000 | {22'd0, exp_pc})) begin mismatched++; $display("FAIL bp_instr j=%0d got %h want %h", j, instr, 32'hC0DE_0000 | {22'd0, exp_pc}); end
            $display("backpressure drain j=%0d: pc=%h", j, instr_pc);
        end
    endtask

    // Branch and jump together: branch wins; target visible three cycles later.
    task automatic test_branch_vs_jump();
        step();
        branch_flag = 1'b1; branch_pc = 10'h100;
        jump_flag = 1'b1;   jump_pc = 10'h200;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL redir_req_n got %b want 0", imem_req); end
        step();
        branch_flag = 1'b0; jump_flag = 1'b0;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 10'h100) begin mismatched++; $display("FAIL redir_req_n1 got req=%b addr=%h want 1/100", imem_req, imem_addr); end
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL redir_valid_n1 got %b want 0", instr_valid); end
        step();
        #1;
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL redir_valid_n2 got %b want 0", instr_valid); end
        compared++; if (imem_addr !== 10'h101) begin mismatched++; $display("FAIL redir_addr_n2 got %h want 101", imem_addr); end
        step();
        #1;
        compared++; if (instr_valid !== 1'b1 || instr_pc !== 10'h100) begin mismatched++; $display("FAIL redir_pc_n3 got v=%b pc=%h want v=1 pc=100", instr_valid, instr_pc); end
        compared++; if (instr !== 32'hC0DE_0100) begin mismatched++; $display("FAIL redir_instr_n3 got %h want c0de0100", instr); end
        step();
        #1;
        compared++; if (instr_valid !== 1'b1 || instr_pc !== 10'h101) begin mismatched++; $display("FAIL redir_pc_n4 got v=%b pc=%h want v=1 pc=101", instr_valid, instr_pc); end
        $display("branch_vs_jump: pc=%h", instr_pc);
    endtask

    // Three stall cycles: in-flight 0x103 still delivered, then 0x104 onward.
    task automatic test_stall();
        step();
        stall = 1'b1;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_req0 got %b want 0", imem_req); end
        compared++; if (instr_pc !== 10'h102 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL stall_pc0 got v=%b pc=%h want v=1 pc=102", instr_valid, instr_pc); end
        step();
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_req1 got %b want 0", imem_req); end
        compared++; if (instr_pc !== 10'h103 || instr_valid !== 1'b1) begin mismatched++; $display("FAIL stall_pc1 got v=%b pc=%h want v=1 pc=103", instr_valid, instr_pc); end
        step();
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_req2 got %b want 0", imem_req); end
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL stall_valid2 got %b want 0", instr_valid); end
        step();
        stall = 1'b0;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 10'h104) begin mismatched++; $display("FAIL stall_resume got req=%b addr=%h want 1/104", imem_req, imem_addr); end
        step();
        step();
        #1;
        compared++; if (instr_valid !== 1'b1 || instr_pc !== 10'h104) begin mismatched++; $display("FAIL stall_after_pc got v=%b pc=%h want v=1 pc=104", instr_valid, instr_pc); end
        step();
        #1;
        compared++; if (instr_valid !== 1'b1 || instr_pc !== 10'h105) begin mismatched++; $display("FAIL stall_after_pc2 got v=%b pc=%h want v=1 pc=105", instr_valid, instr_pc); end
        $display("stall: resumed pc=%h", instr_pc);
    endtask

    // Jump taken during a stall, into the top of the address space.
    task automatic test_wrap();
        logic [9:0] exp_pc [4];
        exp_pc[0] = 10'h3FE; exp_pc[1] = 10'h3FF; exp_pc[2] = 10'h000; exp_pc[3] = 10'h001;
        step();
        stall = 1'b1; jump_flag = 1'b1; jump_pc = 10'h3FE;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL wrap_req_redirect got %b want 0", imem_req); end
        step();
        stall = 1'b0; jump_flag = 1'b0;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 10'h3FE) begin mismatched++; $display("FAIL wrap_first_req got req=%b addr=%h want 1/3fe", imem_req, imem_addr); end
        step();
        #1;
        compared++; if (imem_addr !== 10'h3FF) begin mismatched++; $display("FAIL wrap_addr1 got %h want 3ff", imem_addr); end
        step();
        #1;
        compared++; if (imem_addr !== 10'h000) begin mismatched++; $display("FAIL wrap_addr2 got %h want 000", imem_addr); end
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin step(); #1; end
            compared++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[j]) begin mismatched++; $display("FAIL wrap_pc j=%0d got v=%b pc=%h want v=1 pc=%h", j, instr_valid, instr_pc, exp_pc[j]); end
            $display("wrap j=%0d: pc=%h", j, instr_pc);
        end
    endtask

    // Fill the queue (pcs 0x002, 0x003), then drop reset between edges.
    task automatic test_async_reset();
        step();
        instr_ready = 1'b0;
        #1;
        step();
        #1;
        compared++; if (instr_valid !== 1'b1 || instr_pc !== 10'h002 || imem_req !== 1'b0) begin mismatched++; $display("FAIL areset_full got v=%b pc=%h req=%b want 1/002/0", instr_valid, instr_pc, imem_req); end
        #2;
        reset = 1'b0;
        #1;
        compared++; if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL areset_valid got %b want 0", instr_valid); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL areset_req got %b want 0", imem_req); end
        compared++; if (imem_addr !== 10'h000) begin mismatched++; $display("FAIL areset_addr got %h want 000", imem_addr); end
        step();
        reset = 1'b1; instr_ready = 1'b1;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin mismatched++; $display("FAIL areset_restart got req=%b addr=%h want 1/000", imem_req, imem_addr); end
        step();
        #1;
        compared++; if (instr_valid !== 1'b0 || imem_addr !== 10'h001) begin mismatched++; $display("FAIL areset_c1 got v=%b addr=%h want 0/001", instr_valid, imem_addr); end
        step();
        #1;
        compared++; if (instr_valid !== 1'b1 || instr_pc !== 10'h000 || instr !== 32'hC0DE_0000) begin mismatched++; $display("FAIL areset_first got v=%b pc=%h instr=%h want 1/000/c0de0000", instr_valid, instr_pc, instr); end
        $display("async_reset: restart pc=%h", instr_pc);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_vs_jump();
        test_stall();
        test_wrap();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
